// File: rtl/muldiv_sequencer.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MFHI/MFLO interlock.
// Optional: define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             rd_hi_i,
  input  logic             rd_lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             div_by_zero_o
);
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [W2-1:0]    ONE_2W = {{(W2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;     // negate product / quotient
  logic             rneg_q, rneg_d;   // negate remainder
  logic             dbz_q, dbz_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // operand capture
  logic             is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign is_signed = ~op_i[0];
  assign is_div    = op_i[1];
  assign a_neg     = is_signed & opa_i[WIDTH-1];
  assign b_neg     = is_signed & opb_i[WIDTH-1];
  assign a_mag     = a_neg ? (~opa_i + ONE_W) : opa_i;
  assign b_mag     = b_neg ? (~opb_i + ONE_W) : opb_i;

  // one shift-add multiply step: acc = {partial product, remaining multiplier}
  logic [WIDTH:0]   madd;
  logic [W2-1:0]    mstep;
  assign madd  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign mstep = {madd, acc_q[WIDTH-1:1]};

  // one restoring divide step: acc = {partial remainder, dividend/quotient}
  logic [WIDTH:0]   drem, dtrial;
  logic [W2-1:0]    dstep;
  assign drem   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign dtrial = drem - {1'b0, b_q};
  assign dstep  = dtrial[WIDTH] ? {drem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [CNT_W-1:0] cnt_m1;
  logic             early;
  assign cnt_m1 = cnt_q - 1'b1;

`ifdef MULDIV_EARLY_OUT_EN
  // after this step, cnt_m1 multiplier bits remain at the bottom of acc
  logic [WIDTH-1:0] rem_mask;
  logic [W2-1:0]    mshift;
  assign rem_mask = (ONE_W << cnt_m1) - ONE_W;
  assign early    = ~op_q[1] & ~|(mstep[WIDTH-1:0] & rem_mask);
  assign mshift   = mstep >> cnt_m1;
`else
  assign early = 1'b0;
`endif

  // sign fixup
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  assign prod_fix = neg_q  ? (~acc_q + ONE_2W) : acc_q;
  assign quot_fix = neg_q  ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? (~acc_q[W2-1:WIDTH] + ONE_W) : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        op_d   = op_i;
        dbz_d  = 1'b0;
        neg_d  = a_neg ^ b_neg;
        rneg_d = a_neg;
        cnt_d  = CNT_W'(WIDTH);
        if (is_div) begin
          b_d   = b_mag;
          acc_d = {{WIDTH{1'b0}}, a_mag};
          if (opb_i == '0) begin
            dbz_d   = 1'b1;
            acc_d   = {opa_i, {WIDTH{1'b0}}};
            state_d = S_FIXUP;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          b_d     = a_mag;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = cnt_m1;
        acc_d = op_q[1] ? dstep : mstep;
`ifdef MULDIV_EARLY_OUT_EN
        if (early) acc_d = mshift;
`endif
        if (cnt_q == CNT_W'(1) || early) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (dbz_q) begin
          hi_d = acc_q[W2-1:WIDTH];
          lo_d = {WIDTH{1'b1}};
        end else if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // sign flags only matter for signed ops; unsigned ops never negate
  logic neg_en, rneg_en;
  assign neg_en  = ~op_q[0];
  assign rneg_en = ~op_q[0] & op_q[1];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= (state_q == S_IDLE) ? neg_d  : (neg_q  & neg_en);
      rneg_q  <= (state_q == S_IDLE) ? rneg_d : (rneg_q & rneg_en);
      dbz_q   <= dbz_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign div_by_zero_o = dbz_q;
  // HI/LO are already valid in DONE, so only a new start is held there
  assign stall_o       = busy_o & (start_i | ((rd_hi_i | rd_lo_i) & (state_q != S_DONE)));
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, stall, div-by-zero and reset abort.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0, opb = '0;
  logic        rd_hi = 1'b0, rd_lo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall, done, dbz;
  int checks = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start), .op_i(op),
    .opa_i(opa), .opb_i(opb), .rd_hi_i(rd_hi), .rd_lo_i(rd_lo),
    .hi_o(hi), .lo_o(lo), .busy_o(busy), .stall_o(stall),
    .done_o(done), .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_CYC = 3;
`else
  localparam int EO_CYC = 34;
`endif

  // launch one op, then count busy/stall cycles up to and including the done cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int stl, output bit seen, output bit st_done);
    cyc = 0; stl = 0; seen = 1'b0; st_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; opa = 32'hDEADBEEF; opb = 32'h0; op = ~o;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (stall) stl++;
      if (done) begin seen = 1'b1; st_done = stall; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, stall, done, dbz} !== 4'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset: busy=%b stall=%b done=%b dbz=%b hi=%h lo=%h required all zero",
               busy, stall, done, dbz, hi, lo);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_multu();
    int cyc, stl; bit seen, sd;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, stl, seen, sd);
    checks++;
    if (!seen || cyc !== 34) begin failures++; $display("FAIL multu_latency: seen=%b busy=%0d required 34", seen, cyc); end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      failures++; $display("FAIL multu_result: hi=%h lo=%h required fffffffe 00000001", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL multu_idle: busy=%b done=%b required 0 0", busy, done); end
  endtask

  task automatic test_mult_stall();
    int cyc, stl; bit seen, sd;
    rd_lo = 1'b1;
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, cyc, stl, seen, sd);
    checks++;
    if (!seen || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      failures++; $display("FAIL mult_neg: hi=%h lo=%h required ffffffff fffffffa", hi, lo);
    end
    checks++;
    if (stl !== 33 || sd !== 1'b0) begin
      failures++; $display("FAIL mult_stall: stall_cycles=%0d in_done=%b required 33 0", stl, sd);
    end
    rd_lo = 1'b0;
    run_op(2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, cyc, stl, seen, sd);
    checks++;
    if (!seen || hi !== 32'h0 || lo !== 32'd15) begin
      failures++; $display("FAIL mult_negneg: hi=%h lo=%h required 0 0000000f", hi, lo);
    end
  endtask

  task automatic test_div();
    int cyc, stl; bit seen, sd;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, cyc, stl, seen, sd);
    checks++;
    if (!seen || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || cyc !== 34) begin
      failures++; $display("FAIL div_neg: hi=%h lo=%h busy=%0d required ffffffff fffffffd 34", hi, lo, cyc);
    end
    run_op(2'b11, 32'd100, 32'd7, cyc, stl, seen, sd);
    checks++;
    if (!seen || hi !== 32'd2 || lo !== 32'd14) begin
      failures++; $display("FAIL divu: hi=%0d lo=%0d required 2 14", hi, lo);
    end
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, cyc, stl, seen, sd);
    checks++;
    if (!seen || hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin
      failures++; $display("FAIL div_pos_neg: hi=%h lo=%h required 00000001 fffffffd", hi, lo);
    end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, cyc, stl, seen, sd);
    checks++;
    if (!seen || hi !== 32'h0 || lo !== 32'h80000000) begin
      failures++; $display("FAIL div_overflow: hi=%h lo=%h required 0 80000000", hi, lo);
    end
    checks++;
    if (dbz !== 1'b0) begin failures++; $display("FAIL div_dbz_clear: dbz=%b required 0", dbz); end
  endtask

  task automatic test_div_by_zero();
    int cyc, stl; bit seen, sd;
    run_op(2'b11, 32'h12345678, 32'h0, cyc, stl, seen, sd);
    checks++;
    if (!seen || cyc !== 2) begin failures++; $display("FAIL dbz_latency: seen=%b busy=%0d required 2", seen, cyc); end
    checks++;
    if (hi !== 32'h12345678 || lo !== 32'hFFFFFFFF || dbz !== 1'b1) begin
      failures++; $display("FAIL dbz_result: hi=%h lo=%h dbz=%b required 12345678 ffffffff 1", hi, lo, dbz);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dbz !== 1'b1) begin failures++; $display("FAIL dbz_sticky: dbz=%b required 1", dbz); end
    run_op(2'b01, 32'd2, 32'd3, cyc, stl, seen, sd);
    checks++;
    if (!seen || dbz !== 1'b0 || lo !== 32'd6 || hi !== 32'd0) begin
      failures++; $display("FAIL dbz_then_multu: dbz=%b hi=%0d lo=%0d required 0 0 6", dbz, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    int bad_stall = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b11; opa = 32'd100; opb = 32'd7;
    @(posedge clk); #1;
    op = 2'b01; opa = 32'd9; opb = 32'd9;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && !stall) bad_stall++;
      if (done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || bad_stall != 0 || hi !== 32'd2 || lo !== 32'd14) begin
      failures++; $display("FAIL b2b_first: seen=%b unstalled=%0d hi=%0d lo=%0d required 1 0 2 14", seen, bad_stall, hi, lo);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL b2b_idle: busy=%b stall=%b required 0 0", busy, stall);
    end
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || hi !== 32'd0 || lo !== 32'd81) begin
      failures++; $display("FAIL b2b_second: seen=%b hi=%0d lo=%0d required 1 0 81", seen, hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, stl; bit seen, sd;
    bit done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b01; opa = 32'hFFFF0000; opb = 32'h0000FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_abort: busy=%b hi=%h lo=%h done=%b required 0 0 0 0", busy, hi, lo, done);
    end
    repeat (40) begin @(negedge clk); if (done) done_seen = 1'b1; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done || busy) done_seen = 1'b1; end
    checks++;
    if (done_seen) begin failures++; $display("FAIL reset_no_done: done/busy seen=1 required 0"); end
    run_op(2'b01, 32'd5, 32'd5, cyc, stl, seen, sd);
    checks++;
    if (!seen || lo !== 32'd25 || hi !== 32'd0) begin
      failures++; $display("FAIL reset_recover: hi=%0d lo=%0d required 0 25", hi, lo);
    end
  endtask

  task automatic test_early_out();
    int cyc, stl; bit seen, sd;
    run_op(2'b01, 32'h1234, 32'd1, cyc, stl, seen, sd);
    checks++;
    if (!seen || cyc !== EO_CYC || lo !== 32'h1234 || hi !== 32'h0) begin
      failures++; $display("FAIL early_out_b1: busy=%0d hi=%h lo=%h required %0d 0 1234", cyc, hi, lo, EO_CYC);
    end
    run_op(2'b00, 32'hFFFFFFF0, 32'd0, cyc, stl, seen, sd);
    checks++;
    if (!seen || cyc !== EO_CYC || lo !== 32'h0 || hi !== 32'h0) begin
      failures++; $display("FAIL early_out_b0: busy=%0d hi=%h lo=%h required %0d 0 0", cyc, hi, lo, EO_CYC);
    end
    run_op(2'b00, 32'h7, 32'hFFFFFFFC, cyc, stl, seen, sd);
    checks++;
    if (!seen || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFE4) begin
      failures++; $display("FAIL early_out_signed: hi=%h lo=%h required ffffffff ffffffe4", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_stall();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_reset_abort();
    test_early_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
